// File: rtl/vdp_pkg.sv
// Shared definitions for the CPU->VDP command interface and the sprite engine FSM.
package vdp_pkg;

    // Command codes driven by the CHIP-8 core on the cmd port.
    localparam logic [2:0] VDP_CMD_NONE     = 3'd0;
    localparam logic [2:0] VDP_CMD_SETX     = 3'd1;
    localparam logic [2:0] VDP_CMD_SETY     = 3'd2;
    localparam logic [2:0] VDP_CMD_XOR_BYTE = 3'd3;
    localparam logic [2:0] VDP_CMD_CLEAR    = 3'd4;

    // Sprite engine sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RMW_A = 3'd1,
        ST_RD_B  = 3'd2,
        ST_RMW_B = 3'd3,
        ST_DONE  = 3'd4,
        ST_CLEAR = 3'd5
    } vdp_state_e;

endpackage

// File: rtl/vdp_sprite_align.sv
// Splits a sprite byte across the two frame-buffer bytes it straddles for a
// given pixel offset inside the first byte.
module vdp_sprite_align (
    input  logic [7:0] sprite_byte,
    input  logic [2:0] off,
    output logic [7:0] mask_a,
    output logic [7:0] mask_b,
    output logic       need_b
);

    logic [15:0] wide;

    // Shift the byte through a 16-bit window: upper half lands in byte A,
    // the bits pushed out of it land at the top of byte B.
    always_comb begin
        wide   = {sprite_byte, 8'h00} >> off;
        mask_a = wide[15:8];
        mask_b = wide[7:0];
        need_b = (off != 3'd0);
    end

endmodule

// File: rtl/vdp_sprite_engine.sv
// Command responder of the VDP: SETX/SETY/XOR_BYTE/CLEAR on a 1bpp frame buffer
// with read-modify-write sprite drawing, screen wrap and collision detection.
module vdp_sprite_engine
    import vdp_pkg::*;
#(
    parameter int COLS_LOG2 = 3,
    parameter int ROWS_LOG2 = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [2:0]                     cmd,
    input  logic [7:0]                     cmdData,
    output logic                           busy,
    output logic                           spriteHit,
    output logic [COLS_LOG2+ROWS_LOG2-1:0] vram_addr,
    output logic                           vram_we,
    output logic [7:0]                     vram_wdata,
    input  logic [7:0]                     vram_rdata
);

    localparam int AW = COLS_LOG2 + ROWS_LOG2;
    localparam int XW = COLS_LOG2 + 3;

    vdp_state_e           state_q, state_d;
    logic [XW-1:0]        x_q, x_d;
    logic [ROWS_LOG2-1:0] y_q, y_d;
    logic                 hit_q, hit_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [7:0]           ma_q, ma_d;
    logic [7:0]           mb_q, mb_d;
    logic                 needb_q, needb_d;

    logic [7:0]           align_ma;
    logic [7:0]           align_mb;
    logic                 align_needb;
    logic [COLS_LOG2-1:0] byte_b;
    logic                 we_c;
    logic [7:0]           wdata_c;

    vdp_sprite_align u_align (
        .sprite_byte (cmdData),
        .off         (x_q[2:0]),
        .mask_a      (align_ma),
        .mask_b      (align_mb),
        .need_b      (align_needb)
    );

    // Second byte of an unaligned sprite is the next byte in the same row.
    assign byte_b = x_q[XW-1:3] + 1'b1;

    // Next-state, datapath and write-strobe decode for the command sequencer.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        hit_d   = hit_q;
        addr_d  = addr_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        needb_d = needb_q;
        we_c    = 1'b0;
        wdata_c = 8'h00;
        case (state_q)
            ST_IDLE: begin
                case (cmd)
                    VDP_CMD_SETX: begin
                        x_d   = cmdData[XW-1:0];
                        hit_d = 1'b0;
                    end
                    VDP_CMD_SETY: begin
                        y_d = cmdData[ROWS_LOG2-1:0];
                    end
                    VDP_CMD_XOR_BYTE: begin
                        addr_d  = {y_q, x_q[XW-1:3]};
                        ma_d    = align_ma;
                        mb_d    = align_mb;
                        needb_d = align_needb;
                        state_d = ST_RMW_A;
                    end
                    VDP_CMD_CLEAR: begin
                        addr_d  = '0;
                        hit_d   = 1'b0;
                        state_d = ST_CLEAR;
                    end
                    default: ;
                endcase
            end
            ST_RMW_A: begin
                we_c    = 1'b1;
                wdata_c = vram_rdata ^ ma_q;
                if ((vram_rdata & ma_q) != 8'h00) begin
                    hit_d = 1'b1;
                end
                state_d = needb_q ? ST_RD_B : ST_DONE;
            end
            ST_RD_B: begin
                addr_d  = {y_q, byte_b};
                state_d = ST_RMW_B;
            end
            ST_RMW_B: begin
                we_c    = 1'b1;
                wdata_c = vram_rdata ^ mb_q;
                if ((vram_rdata & mb_q) != 8'h00) begin
                    hit_d = 1'b1;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                y_d     = y_q + 1'b1;
                state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                we_c    = 1'b1;
                wdata_c = 8'h00;
                addr_d  = addr_q + 1'b1;
                if (addr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any command in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            hit_q   <= 1'b0;
            addr_q  <= '0;
            ma_q    <= 8'h00;
            mb_q    <= 8'h00;
            needb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hit_q   <= hit_d;
            addr_q  <= addr_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            needb_q <= needb_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign spriteHit  = hit_q;
    assign vram_addr  = addr_q;
    assign vram_we    = we_c;
    assign vram_wdata = wdata_c;

endmodule

// File: tb/tb_vdp_sprite_engine.sv
// Scoreboard bench for vdp_sprite_engine: a pixel-level screen model predicts
// every VRAM write; a monitor compares the writes the DUT actually issues.
module tb_vdp_sprite_engine;
    import vdp_pkg::*;

    logic       clk;
    logic       reset;
    logic [2:0] cmd;
    logic [7:0] cmdData;
    logic       busy;
    logic       spriteHit;
    logic [7:0] vram_addr;
    logic       vram_we;
    logic [7:0] vram_wdata;
    logic [7:0] vram_rdata;

    vdp_sprite_engine #(.COLS_LOG2(3), .ROWS_LOG2(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd),
        .cmdData    (cmdData),
        .busy       (busy),
        .spriteHit  (spriteHit),
        .vram_addr  (vram_addr),
        .vram_we    (vram_we),
        .vram_wdata (vram_wdata),
        .vram_rdata (vram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM: address register lives in the DUT, so read data follows vram_addr.
    logic [7:0] mem [256];
    logic       bd_we;
    logic       bd_fill;
    logic [7:0] bd_addr;
    logic [7:0] bd_data;
    assign vram_rdata = mem[vram_addr];

    always @(posedge clk) begin
        if (vram_we) mem[vram_addr] <= vram_wdata;
        else if (bd_fill) for (int i = 0; i < 256; i++) mem[i] <= bd_data;
        else if (bd_we) mem[bd_addr] <= bd_data;
    end

    // Reference model: screen as individual pixels.
    bit pix [32][64];
    int mx, my;
    bit mhit;

    typedef struct { int addr; int data; } wr_t;
    wr_t exp_q[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int model_byte(input int addr);
        int v = 0;
        for (int i = 0; i < 8; i++)
            if (pix[addr / 8][(addr % 8) * 8 + i]) v |= (1 << (7 - i));
        return v;
    endfunction

    task automatic model_set_byte(input int addr, input int val);
        for (int i = 0; i < 8; i++)
            pix[addr / 8][(addr % 8) * 8 + i] = ((val >> (7 - i)) & 1) != 0;
    endtask

    // XOR a sprite byte into the pixel model and predict the byte writes.
    task automatic model_xor(input logic [7:0] d, input bit only_a);
        int off = mx % 8;
        int ba  = my * 8 + mx / 8;
        int bb  = my * 8 + ((mx / 8) + 1) % 8;
        for (int i = 0; i < 8; i++) begin
            if (d[7 - i] && !(only_a && i >= 8 - off)) begin
                int px = (mx + i) % 64;
                if (pix[my][px]) mhit = 1'b1;
                pix[my][px] = !pix[my][px];
            end
        end
        exp_q.push_back('{ba, model_byte(ba)});
        if (off != 0 && !only_a) exp_q.push_back('{bb, model_byte(bb)});
        if (!only_a) my = (my + 1) % 32;
    endtask

    // Monitor: every DUT write must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset && vram_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr=%0d data=0x%0h, expected no write", vram_addr, vram_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", int'(vram_addr), e.addr);
                check("wr_data", int'(vram_wdata), e.data);
            end
        end
    end

    task automatic bd_write(input int addr, input int val);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = 8'(addr); bd_data = 8'(val);
        @(negedge clk);
        bd_we = 1'b0;
        model_set_byte(addr, val);
    endtask

    task automatic bd_fill_all(input int val);
        @(negedge clk);
        bd_fill = 1'b1; bd_data = 8'(val);
        @(negedge clk);
        bd_fill = 1'b0;
        for (int a = 0; a < 256; a++) model_set_byte(a, val);
    endtask

    // Issue one command and count the cycles busy stays high (bounded).
    task automatic do_cmd(input logic [2:0] c, input logic [7:0] d, input int inject_at, output int n);
        @(negedge clk);
        cmd = c; cmdData = d;
        @(negedge clk);
        cmd = VDP_CMD_NONE;
        n = 0;
        while (busy && n < 400) begin
            n++;
            if (inject_at != 0 && n == inject_at) begin
                cmd = VDP_CMD_SETX; cmdData = 8'd33;
            end else begin
                cmd = VDP_CMD_NONE;
            end
            @(negedge clk);
        end
        cmd = VDP_CMD_NONE;
        if (n >= 400) check("busy_timeout", n, 0);
    endtask

    task automatic cmd_setx(input logic [7:0] d);
        int n;
        mx = d % 64; mhit = 1'b0;
        do_cmd(VDP_CMD_SETX, d, 0, n);
        check("setx_busy", n, 0);
        check("setx_hit", int'(spriteHit), int'(mhit));
    endtask

    task automatic cmd_sety(input logic [7:0] d);
        int n;
        my = d % 32;
        do_cmd(VDP_CMD_SETY, d, 0, n);
        check("sety_busy", n, 0);
    endtask

    task automatic cmd_xor(input logic [7:0] d);
        int n;
        int expb = (mx % 8 == 0) ? 2 : 4;
        model_xor(d, 1'b0);
        do_cmd(VDP_CMD_XOR_BYTE, d, 0, n);
        check("xor_busy", n, expb);
        check("xor_hit", int'(spriteHit), int'(mhit));
        check("xor_drain", exp_q.size(), 0);
    endtask

    task automatic cmd_clear(input int inject_at);
        int n;
        for (int a = 0; a < 256; a++) begin
            exp_q.push_back('{a, 0});
            model_set_byte(a, 0);
        end
        mhit = 1'b0;
        do_cmd(VDP_CMD_CLEAR, 8'h00, inject_at, n);
        check("clear_busy", n, 256);
        check("clear_hit", int'(spriteHit), 0);
        check("clear_drain", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bval, mism;
        reset = 1'b0; cmd = VDP_CMD_NONE; cmdData = 8'h00;
        bd_we = 1'b0; bd_fill = 1'b0; bd_addr = 8'h00; bd_data = 8'h00;
        mx = 0; my = 0; mhit = 1'b0;
        bd_fill_all(0);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_hit", int'(spriteHit), 0);
        check("rst_we", int'(vram_we), 0);
        check("rst_addr", int'(vram_addr), 0);
        check("rst_wdata", int'(vram_wdata), 0);
        reset = 1'b1;

        // 1: draw then erase at the origin
        cmd_setx(0); cmd_sety(0); cmd_xor(8'hF0);
        check("t1_mem0", int'(mem[0]), 8'hF0);
        check("t1_hit0", int'(spriteHit), 0);
        cmd_sety(0); cmd_xor(8'hF0);
        check("t1_mem0b", int'(mem[0]), 8'h00);
        check("t1_hit1", int'(spriteHit), 1);

        // 2: unaligned byte on the last row, then vertical wrap to row 0
        cmd_setx(13); cmd_sety(31); cmd_xor(8'hFF);
        check("t2_a249", int'(mem[249]), 8'h07);
        check("t2_a250", int'(mem[250]), 8'hF8);
        cmd_xor(8'h81);

        // 3: horizontal wrap inside a row, SETX modulo 64
        cmd_setx(61); cmd_sety(2); cmd_xor(8'hFF);
        check("t3_a23", int'(mem[23]), 8'h07);
        check("t3_a16", int'(mem[16]), 8'hF8);
        cmd_setx(70); cmd_xor(8'h80);

        // 4: collision on a pre-filled pixel, cleared by SETX
        bd_write(5, 8'h01);
        cmd_setx(40); cmd_sety(0); cmd_xor(8'h01);
        check("t4_a5", int'(mem[5]), 8'h00);
        check("t4_hit", int'(spriteHit), 1);
        cmd_setx(0);
        check("t4_hitclr", int'(spriteHit), 0);

        // 5: CLEAR over a full screen, SETX mid-clear must be ignored
        bd_fill_all(8'hFF);
        cmd_clear(100);
        cmd_xor(8'hA5);

        // Randomized command mix
        for (int it = 0; it < 80; it++) begin
            int r = $urandom_range(0, 9);
            if (r < 2) cmd_setx(8'($urandom_range(0, 255)));
            else if (r < 4) cmd_sety(8'($urandom_range(0, 255)));
            else if (r < 8) cmd_xor(8'($urandom_range(0, 255)));
            else if (r == 8) begin
                logic [2:0] c;
                c = 3'($urandom_range(5, 8) % 8);
                do_cmd(c, 8'($urandom_range(0, 255)), 0, n);
                check("noop_busy", n, 0);
                check("noop_hit", int'(spriteHit), int'(mhit));
            end else begin
                bd_write($urandom_range(0, 255), $urandom_range(0, 255));
            end
        end

        // 6: reset during the second read-modify-write of an unaligned byte
        cmd_setx(13); cmd_sety(4);
        bval = model_byte(4 * 8 + 2);
        model_xor(8'hFF, 1'b1);
        @(negedge clk);
        cmd = VDP_CMD_XOR_BYTE; cmdData = 8'hFF;
        @(negedge clk);
        cmd = VDP_CMD_NONE;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("t6_we_before", int'(vram_we), 1);
        check("t6_addr_before", int'(vram_addr), 34);
        reset = 1'b0;
        #1;
        check("t6_we", int'(vram_we), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_hit", int'(spriteHit), 0);
        check("t6_addr", int'(vram_addr), 0);
        mx = 0; my = 0; mhit = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("t6_noB", int'(mem[34]), bval);
        check("t6_drain", exp_q.size(), 0);
        cmd_xor(8'hC3);

        // Final full-screen comparison of VRAM against the model
        @(negedge clk);
        mism = 0;
        for (int a = 0; a < 256; a++) if (int'(mem[a]) != model_byte(a)) mism++;
        check("vram_image", mism, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
